// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer and arbiter.
// It merges the JTAG, watchdog and software reset requests into one sequenced reset.
// Both resets stay asserted for HOLD_CYCLES after the last request.
// After that the peripheral domain is released, and the core domain follows STAGE_GAP cycles later.
// Optional macro RST_SEQ_CAUSE_EN adds a sticky reset-cause register on cause_o.
module rst_seq_ctrl #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned CW          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_jtag_i,
  input  logic       req_wdg_i,
  input  logic       req_sw_i,
  input  logic       cause_clr_i,
  output logic       periph_rst_n_o,
  output logic       core_rst_n_o,
  output logic       busy_o,
  output logic [3:0] cause_o
);

  typedef enum logic [1:0] {
    ASSERT = 2'b00,
    REL_P  = 2'b01,
    RUN    = 2'b10
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          periph_q, periph_d;
  logic          core_q, core_d;
  logic          busy_q, busy_d;
  logic          req_any;

  assign req_any = req_jtag_i | req_wdg_i | req_sw_i;

  // Next-state logic: the counter is compared before it increments and is cleared on every transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    periph_d = periph_q;
    core_d   = core_q;
    busy_d   = busy_q;
    case (state_q)
      ASSERT: begin
        periph_d = 1'b0;
        core_d   = 1'b0;
        busy_d   = 1'b1;
        if (req_any) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d  = REL_P;
          periph_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REL_P: begin
        if (req_any) begin
          state_d  = ASSERT;
          periph_d = 1'b0;
          cnt_d    = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = RUN;
          core_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (req_any) begin
          state_d  = ASSERT;
          periph_d = 1'b0;
          core_d   = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d  = ASSERT;
        cnt_d    = '0;
        periph_d = 1'b0;
        core_d   = 1'b0;
        busy_d   = 1'b1;
      end
    endcase
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ASSERT;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      busy_q   <= busy_d;
    end
  end

  assign periph_rst_n_o = periph_q;
  assign core_rst_n_o   = core_q;
  assign busy_o         = busy_q;

`ifdef RST_SEQ_CAUSE_EN
  logic [3:0] cause_q, cause_d;

  // Sticky cause bits. A clear is applied before this cycle's new requests are OR-ed in.
  always_comb begin
    cause_d = cause_clr_i ? 4'b0000 : cause_q;
    cause_d = cause_d | {1'b0, req_jtag_i, req_wdg_i, req_sw_i};
  end

  // Cause register. Only rst sets the power-on bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= 4'b1000;
    end else begin
      cause_q <= cause_d;
    end
  end

  assign cause_o = cause_q;
`else
  logic unused_cause_clr;
  assign unused_cause_clr = cause_clr_i;
  assign cause_o          = '0;
`endif

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencer/arbiter that sits downstream of the synchronised external/JTAG reset logic.
- Merges reset requests from JTAG, watchdog and software into one sequenced reset.
- Enforces a minimum assertion time.
- Releases the peripheral domain first and the core domain a fixed gap later.
- Optionally records which sources caused the last reset.

Parameters:
HOLD_CYCLES, 16, minimum cycles both resets stay asserted after the last active request; range 1..2**CW-1
STAGE_GAP, 4, cycles between peripheral release and core release; range 1..2**CW-1
CW, 8, width of the internal sequencing counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset (already-synchronised external reset)
req_jtag_i  input  1  JTAG reset request, level; held high = hold reset
req_wdg_i  input  1  watchdog reset request, single-cycle pulse
req_sw_i  input  1  software reset request, single-cycle pulse
cause_clr_i  input  1  clear cause register (used only with RST_SEQ_CAUSE_EN)
periph_rst_n_o  output  1  peripheral-domain reset, active-low, registered
core_rst_n_o  output  1  core-domain reset, active-low, registered
busy_o  output  1  high while any reset sequencing is in progress
cause_o  output  4  reset cause bitmask {por, jtag, wdg, sw}

Behaviour:
- One clock (clk). Reset is synchronous and active-high on rst. All outputs are registered.
- req_any = req_jtag_i | req_wdg_i | req_sw_i.
- On rst=1, registered values:
  - state=ASSERT, cnt=0
  - periph_rst_n_o=0, core_rst_n_o=0, busy_o=1
  - cause_o=4'b1000 (macro on) or 0 (macro off)
- FSM states:
  - ASSERT: both resets low, busy=1.
    - req_any=1: cnt<=0, stay in ASSERT.
    - Otherwise, if cnt==HOLD_CYCLES-1: go to REL_P, periph_rst_n_o<=1, cnt<=0.
    - Otherwise: cnt<=cnt+1.
  - REL_P: periph high, core low, busy=1.
    - req_any=1: go to ASSERT, periph_rst_n_o<=0, cnt<=0.
    - Otherwise, if cnt==STAGE_GAP-1: go to RUN, core_rst_n_o<=1, busy_o<=0.
    - Otherwise: cnt<=cnt+1.
  - RUN: both resets high, busy=0.
    - req_any=1: go to ASSERT, both resets <=0, busy_o<=1, cnt<=0.
- Latency:
  - Request sampled at edge N: resets are low after edge N+1 (one-cycle latency), from any state.
  - After the last cycle with rst or req_any high, periph releases exactly HOLD_CYCLES edges later.
  - Core releases STAGE_GAP edges after periph; busy_o falls on the same edge as core release.
- A held req_jtag_i keeps cnt at 0, so reset is held for the whole request plus HOLD_CYCLES.
- Simultaneous requests from several sources behave as one request.
- A request during REL_P restarts the full sequence. Peripheral reset is re-asserted; no partial release occurs.
- Counter never wraps: it is compared before incrementing and cleared on every state change.
- rst mid-sequence overrides everything; behaviour is identical to the power-on reset values.
- Reserved/illegal state encodings go to ASSERT with cnt=0.

Optional Feature:
Macro: RST_SEQ_CAUSE_EN.
- Defined:
  - cause_o is a sticky bitmask. Bit0 sets on req_sw_i, bit1 on req_wdg_i, bit2 on req_jtag_i; bit3 is set only by rst.
  - cause_clr_i=1 clears all bits.
  - If cause_clr_i coincides with a request, the result equals the bits of the new requests only (clear first, then set).
  - Bits update one edge after sampling.
- Not defined: cause_o is constant 4'b0000, cause_clr_i is ignored, and no cause flops are implemented.

Test Plan:
1. rst high 3 cycles then low (HOLD=16, GAP=4) -> periph_rst_n_o rises 16 edges after the last rst-high cycle; core_rst_n_o and busy_o change 4 edges later; cause_o=4'b1000.
2. In RUN, 1-cycle req_wdg_i pulse -> next edge both resets 0 and busy_o=1; periph high 16 edges after the pulse, core 20 edges after; cause_o=4'b1010.
3. req_jtag_i held 50 cycles in RUN -> resets low for all 50 cycles; periph releases 16 edges after deassert, core at 20.
4. req_sw_i pulse 2 cycles into REL_P -> periph_rst_n_o falls next edge; full 16+4 sequence restarts from the pulse.
5. cause_o=4'b1010, then cause_clr_i and req_sw_i in the same cycle -> cause_o=4'b0001. With macro off -> cause_o stays 0 throughout.
6. rst asserted for 1 cycle during REL_P -> next edge both resets 0, cnt cleared, cause_o=4'b1000; normal 16/20 release follows.
